decoder_seq_ctrl: RTL and testbench

Board-level sequencer that drives the 3-bit select input of the LED decoder on the DE1-SoC, replacing the raw push-button clocking of the decoder. Runs from CLOCK_50, debounces a push-button and either loads the slide-switch value on each press (manual) or auto-scans the select through all 8 codes at a programmable rate (auto, with press = pause/resume). Sits between the board pins (KEY, SW) and the decoder's select input.

---
 rtl/decoder_seq_ctrl.sv | 155 +++++++++++++++
 tb/tb_decoder_seq_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder_seq_ctrl.sv
// ============================================================================
// Module   : decoder_seq_ctrl
// Purpose  : Debounced push-button sequencer that drives the LED decoder
//            select, in either manual-load or auto-scan mode.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decoder_seq_ctrl #(
  parameter int SEL_W           = 3,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int STEP_CYCLES     = 25000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             key_n,
  input  logic             mode,
  input  logic             dir,
  input  logic [SEL_W-1:0] sw_sel,
  output logic [SEL_W-1:0] sel,
  output logic             step,
  output logic [1:0]       state
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PS_W = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(STEP_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_MANUAL     = 2'b00,
    ST_AUTO_RUN   = 2'b01,
    ST_AUTO_PAUSE = 2'b10
  } state_t;

  logic             key_meta_q, key_sync_q;
  logic             mode_meta_q, mode_sync_q;
  logic             dir_meta_q, dir_sync_q;
  logic [SEL_W-1:0] sw_meta_q, sw_sync_q;

  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             db_level_q, db_level_d;
  logic             db_prev_q;
  logic             press_q, press_d;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             step_q, step_d;
  logic [PS_W-1:0]  presc_q, presc_d;

  // Key synchronizer resets to released (high); switches reset low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta_q  <= 1'b1;
      key_sync_q  <= 1'b1;
      mode_meta_q <= 1'b0;
      mode_sync_q <= 1'b0;
      dir_meta_q  <= 1'b0;
      dir_sync_q  <= 1'b0;
      sw_meta_q   <= '0;
      sw_sync_q   <= '0;
    end else begin
      key_meta_q  <= key_n;
      key_sync_q  <= key_meta_q;
      mode_meta_q <= mode;
      mode_sync_q <= mode_meta_q;
      dir_meta_q  <= dir;
      dir_sync_q  <= dir_meta_q;
      sw_meta_q   <= sw_sel;
      sw_sync_q   <= sw_meta_q;
    end
  end

  // Count consecutive cycles that the synchronized key disagrees with the
  // accepted level; any agreeing cycle restarts the count.
  always_comb begin
    db_cnt_d   = db_cnt_q;
    db_level_d = db_level_q;
    if (key_sync_q == db_level_q) begin
      db_cnt_d = '0;
    end else if (db_cnt_q == DB_LAST) begin
      db_level_d = key_sync_q;
      db_cnt_d   = '0;
    end else begin
      db_cnt_d = db_cnt_q + 1'b1;
    end
    press_d = db_prev_q & ~db_level_q;
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    step_d  = 1'b0;
    presc_d = presc_q;
    case (state_q)
      ST_MANUAL: begin
        if (mode_sync_q) begin
          state_d = ST_AUTO_RUN;
          presc_d = '0;
        end else if (press_q) begin
          sel_d  = sw_sync_q;
          step_d = 1'b1;
        end
      end
      ST_AUTO_RUN: begin
        if (!mode_sync_q) begin
          state_d = ST_MANUAL;
        end else begin
          if (presc_q == PS_LAST) begin
            presc_d = '0;
            sel_d   = dir_sync_q ? (sel_q - 1'b1) : (sel_q + 1'b1);
            step_d  = 1'b1;
          end else begin
            presc_d = presc_q + 1'b1;
          end
          if (press_q) state_d = ST_AUTO_PAUSE;
        end
      end
      ST_AUTO_PAUSE: begin
        if (!mode_sync_q)  state_d = ST_MANUAL;
        else if (press_q)  state_d = ST_AUTO_RUN;
      end
      default: state_d = ST_MANUAL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_q   <= '0;
      db_level_q <= 1'b1;
      db_prev_q  <= 1'b1;
      press_q    <= 1'b0;
      state_q    <= ST_MANUAL;
      sel_q      <= '0;
      step_q     <= 1'b0;
      presc_q    <= '0;
    end else begin
      db_cnt_q   <= db_cnt_d;
      db_level_q <= db_level_d;
      db_prev_q  <= db_level_q;
      press_q    <= press_d;
      state_q    <= state_d;
      sel_q      <= sel_d;
      step_q     <= step_d;
      presc_q    <= presc_d;
    end
  end

  assign sel   = sel_q;
  assign step  = step_q;
  assign state = state_q;

endmodule

`default_nettype wire

// File: tb/tb_decoder_seq_ctrl.sv
// ============================================================================
// Module   : tb_decoder_seq_ctrl
// Purpose  : Directed self-checking bench for decoder_seq_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decoder_seq_ctrl;

  localparam int SEL_W = 3;

  logic             clk = 1'b0;
  logic             rst_n, key_n, mode, dir;
  logic [SEL_W-1:0] sw_sel;
  logic [SEL_W-1:0] sel;
  logic             step;
  logic [1:0]       state;

  int errors = 0;
  int checks = 0;
  int steps_seen = 0;

  typedef struct {
    int               key_low;
    logic [SEL_W-1:0] sw;
    int               exp_steps;
    logic [SEL_W-1:0] exp_sel;
  } vec_t;

  vec_t vecs[8];

  decoder_seq_ctrl #(
    .SEL_W          (SEL_W),
    .DEBOUNCE_CYCLES(4),
    .STEP_CYCLES    (5)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_n  (key_n),
    .mode   (mode),
    .dir    (dir),
    .sw_sel (sw_sel),
    .sel    (sel),
    .step   (step),
    .state  (state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    if (step === 1'b1) steps_seen++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic press_win(input int low, input int idle);
    key_n = 1'b0;
    repeat (low) tick();
    key_n = 1'b1;
    repeat (idle) tick();
  endtask

  task automatic wait_step(input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (step !== 1'b1 && n < max);
  endtask

  task automatic wait_state(input logic [1:0] exp, input int max, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (state !== exp && n < max);
  endtask

  initial begin
    int n;
    int first;
    logic [SEL_W-1:0] up_exp[4];
    logic [SEL_W-1:0] dn_exp[3];

    vecs[0] = '{2,  3'd2, 0, 3'd5};
    vecs[1] = '{3,  3'd1, 0, 3'd5};
    vecs[2] = '{4,  3'd1, 1, 3'd1};
    vecs[3] = '{20, 3'd6, 1, 3'd6};
    vecs[4] = '{10, 3'd6, 1, 3'd6};
    vecs[5] = '{6,  3'd0, 1, 3'd0};
    vecs[6] = '{12, 3'd7, 1, 3'd7};
    vecs[7] = '{8,  3'd5, 1, 3'd5};
    up_exp  = '{3'd6, 3'd7, 3'd0, 3'd1};
    dn_exp  = '{3'd0, 3'd7, 3'd6};

    rst_n = 1'b1; key_n = 1'b1; mode = 1'b0; dir = 1'b0; sw_sel = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_sel", sel, 0);
    chk("reset_state", state, 0);
    chk("reset_step", step, 0);
    repeat (3) tick();
    rst_n = 1'b1;

    // Idle in manual mode.
    steps_seen = 0;
    repeat (100) tick();
    chk("idle_steps", steps_seen, 0);
    chk("idle_sel", sel, 0);
    chk("idle_state", state, 0);

    // Manual load latency: pin low to sel update is 2 + 4 + 2 cycles.
    sw_sel = 3'd5;
    key_n = 1'b0;
    steps_seen = 0;
    first = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (step === 1'b1 && first < 0) first = i;
    end
    key_n = 1'b1;
    chk("load_latency", first, 8);
    chk("load_steps", steps_seen, 1);
    chk("load_sel", sel, 5);
    steps_seen = 0;
    repeat (20) tick();
    chk("release_steps", steps_seen, 0);

    for (int v = 0; v < 8; v++) begin
      sw_sel = vecs[v].sw;
      steps_seen = 0;
      press_win(vecs[v].key_low, 20);
      chk($sformatf("vec%0d_steps", v), steps_seen, vecs[v].exp_steps);
      chk($sformatf("vec%0d_sel", v), sel, vecs[v].exp_sel);
      chk($sformatf("vec%0d_state", v), state, 0);
    end

    // Auto scan up, then down.
    mode = 1'b1;
    dir  = 1'b0;
    tick(); tick();
    chk("auto_enter_early", state, 0);
    tick();
    chk("auto_enter", state, 1);
    for (int k = 0; k < 4; k++) begin
      wait_step(10, n);
      chk($sformatf("up%0d_period", k), n, 5);
      chk($sformatf("up%0d_sel", k), sel, up_exp[k]);
    end
    dir = 1'b1;
    for (int k = 0; k < 3; k++) begin
      wait_step(10, n);
      chk($sformatf("dn%0d_period", k), n, 5);
      chk($sformatf("dn%0d_sel", k), sel, dn_exp[k]);
    end

    // Pause, hold, resume with the remaining prescaler count.
    key_n = 1'b0;
    steps_seen = 0;
    wait_state(2'b10, 20, n);
    chk("pause_latency", n, 8);
    chk("pause_steps", steps_seen, 1);
    chk("pause_sel", sel, 5);
    key_n = 1'b1;
    steps_seen = 0;
    repeat (30) tick();
    chk("frozen_steps", steps_seen, 0);
    chk("frozen_sel", sel, 5);
    chk("frozen_state", state, 2);
    key_n = 1'b0;
    wait_state(2'b01, 20, n);
    chk("resume_latency", n, 8);
    key_n = 1'b1;
    wait_step(10, n);
    chk("resume_first_step", n, 2);
    chk("resume_sel", sel, 4);

    // Press lands on the terminal count.
    tick(); tick();
    key_n = 1'b0;
    steps_seen = 0;
    repeat (8) tick();
    chk("coinc_step", step, 1);
    chk("coinc_state", state, 2);
    chk("coinc_sel", sel, 2);
    chk("coinc_steps", steps_seen, 2);
    key_n = 1'b1;
    repeat (20) tick();

    // Mode drop lands on the same cycle as a press.
    key_n = 1'b0;
    repeat (5) tick();
    mode = 1'b0;
    repeat (2) tick();
    chk("modepress_before", state, 2);
    tick();
    chk("modepress_state", state, 0);
    chk("modepress_sel", sel, 2);
    chk("modepress_step", step, 0);
    key_n = 1'b1;
    steps_seen = 0;
    repeat (20) tick();
    chk("modepress_after_steps", steps_seen, 0);
    chk("modepress_after_sel", sel, 2);

    // Asynchronous reset in the middle of an auto scan.
    mode = 1'b1;
    dir  = 1'b0;
    wait_step(15, n);
    chk("pre_rst_latency", n, 8);
    chk("pre_rst_sel", sel, 3);
    tick(); tick();
    rst_n = 1'b0;
    #2;
    chk("async_rst_sel", sel, 0);
    chk("async_rst_state", state, 0);
    chk("async_rst_step", step, 0);
    mode = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    steps_seen = 0;
    repeat (50) tick();
    chk("post_rst_steps", steps_seen, 0);
    chk("post_rst_state", state, 0);
    chk("post_rst_sel", sel, 0);
    sw_sel = 3'd6;
    steps_seen = 0;
    press_win(8, 20);
    chk("post_rst_load_steps", steps_seen, 1);
    chk("post_rst_load_sel", sel, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
